ext_bus_bridge: RTL and testbench

EXT_BUS_BRIDGE -- requirements
Module: ext_bus_bridge

---
 rtl/ext_bus_pkg.sv | 26 ++
 rtl/ext_bus_bridge_lane_seq.sv | 26 ++
 rtl/ext_bus_bridge.sv | 183 ++++++++++++++++++
 tb/tb_ext_bus_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and helpers for the external bus bridge.
//   bus_state_t : bridge sequencer states
//   calc_nl     : byte lanes for a CPU data width
//   calc_ab     : byte-index width for a CPU data width
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_HI,
        A_MID,
        A_LO,
        DATA,
        HOLD,
        DONE,
        RECOV
    } bus_state_t;

    function automatic int calc_nl(input int rv);
        return rv / 8;
    endfunction

    function automatic int calc_ab(input int rv);
        return $clog2(rv / 8);
    endfunction

endpackage

// File: rtl/ext_bus_bridge_lane_seq.sv
// lane_seq: next-set-bit finder over the remaining byte-lane mask.
//   mask : lanes not yet transferred
//   idx  : lowest set lane in mask (next lane to transfer)
//   rest : mask with that lane removed
//   last : idx is the final lane of the transaction
module lane_seq #(
    parameter int NL = 2,
    parameter int AB = 1
) (
    input  logic [NL-1:0] mask,
    output logic [AB-1:0] idx,
    output logic [NL-1:0] rest,
    output logic          last
);

    always_comb begin
        idx = '0;
        // Descending scan so the lowest set bit is the one left standing.
        for (int i = NL - 1; i >= 0; i--) begin
            if (mask[i]) idx = AB'(i);
        end
        rest = mask & (mask - NL'(1));
        last = (rest == '0);
    end

endmodule

// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge: CPU read/write port to an 8-bit multiplexed external bus.
//   clk, reset_in (async, active-high), ena (global clock enable)
//   raddr/rreq -> rdata/rdone : read word address, lane mask, data, done pulse
//   waddr/wmask/wdata -> wdone : write word address, lane mask, data, done pulse
//   bus_out/bus_in            : multiplexed address/data byte to/from pads
//   latch_hi/latch_lo         : external address-latch strobes
//   bus_wr, bus_ind           : write strobe, byte index within the word
// Every output is registered: each transition loads the outputs of the
// state being entered.
module ext_bus_bridge
    import ext_bus_pkg::*;
#(
    parameter  int RV   = 16,
    parameter  int PV   = 18,
    parameter  int WAIT = 0,
    localparam int NL   = calc_nl(RV),
    localparam int AB   = calc_ab(RV)
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             ena,
    input  logic [PV-AB-1:0] raddr,
    input  logic [NL-1:0]    rreq,
    output logic [RV-1:0]    rdata,
    output logic             rdone,
    input  logic [PV-AB-1:0] waddr,
    input  logic [NL-1:0]    wmask,
    input  logic [RV-1:0]    wdata,
    output logic             wdone,
    output logic [7:0]       bus_out,
    input  logic [7:0]       bus_in,
    output logic             latch_hi,
    output logic             latch_lo,
    output logic             bus_wr,
    output logic [AB-1:0]    bus_ind
);

    localparam int WA = PV - AB;

    bus_state_t      state;
    logic [WA-1:0]   addr_q;
    logic            is_wr;
    logic [NL-1:0]   rem;        // lanes not yet started
    logic [RV-1:0]   wdata_q;
    logic [2:0]      hold_cnt;
    logic            cur_last;
    logic [PV-9:0]   cache_tag;  // byte address bits [PV-1:8] last latched
    logic            cache_vld;

    // Write wins over read when both are requested.
    logic            sel_wr;
    logic [WA-1:0]   sel_addr;
    logic [NL-1:0]   sel_mask;
    logic [PV-1:0]   sel_baddr;
    logic [PV-1:0]   baddr;
    logic            sel_hit;
    logic            lane_end;
    logic [AB-1:0]   lane_idx;
    logic [NL-1:0]   lane_rest;
    logic            lane_last;
    logic [7:0]      lane_byte;

    assign sel_wr    = (wmask != '0);
    assign sel_addr  = sel_wr ? waddr : raddr;
    assign sel_mask  = sel_wr ? wmask : rreq;
    assign sel_baddr = {sel_addr, {AB{1'b0}}};
    assign baddr     = {addr_q, {AB{1'b0}}};
    assign sel_hit   = cache_vld && (sel_baddr[PV-1:8] == cache_tag);
    assign lane_end  = (hold_cnt == 3'(WAIT));
    assign lane_byte = is_wr ? wdata_q[lane_idx*8 +: 8] : 8'h00;

    lane_seq #(.NL(NL), .AB(AB)) u_lane_seq (
        .mask (rem),
        .idx  (lane_idx),
        .rest (lane_rest),
        .last (lane_last)
    );

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state     <= IDLE;
            addr_q    <= '0;
            is_wr     <= 1'b0;
            rem       <= '0;
            wdata_q   <= '0;
            hold_cnt  <= '0;
            cur_last  <= 1'b0;
            cache_tag <= '0;
            cache_vld <= 1'b0;
            rdata     <= '0;
            rdone     <= 1'b0;
            wdone     <= 1'b0;
            bus_out   <= '0;
            latch_hi  <= 1'b0;
            latch_lo  <= 1'b0;
            bus_wr    <= 1'b0;
            bus_ind   <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    bus_out  <= '0;
                    latch_hi <= 1'b0;
                    latch_lo <= 1'b0;
                    bus_wr   <= 1'b0;
                    bus_ind  <= '0;
                    rdone    <= 1'b0;
                    wdone    <= 1'b0;
                    if (sel_mask != '0) begin
                        addr_q  <= sel_addr;
                        is_wr   <= sel_wr;
                        rem     <= sel_mask;
                        wdata_q <= wdata;
                        if (sel_hit) begin
                            state    <= A_LO;
                            bus_out  <= sel_baddr[7:0];
                            latch_lo <= 1'b1;
                        end else begin
                            state    <= A_HI;
                            bus_out  <= 8'(sel_baddr[PV-1:16]);
                            latch_hi <= 1'b1;
                        end
                    end
                end
                A_HI: begin
                    state     <= A_MID;
                    bus_out   <= baddr[15:8];
                    latch_hi  <= 1'b1;
                    latch_lo  <= 1'b1;
                    cache_tag <= baddr[PV-1:8];
                    cache_vld <= 1'b1;
                end
                A_MID: begin
                    state    <= A_LO;
                    bus_out  <= baddr[7:0];
                    latch_hi <= 1'b0;
                    latch_lo <= 1'b1;
                end
                A_LO: begin
                    latch_lo <= 1'b0;
                    state    <= DATA;
                    bus_ind  <= lane_idx;
                    bus_out  <= lane_byte;
                    bus_wr   <= is_wr;
                    cur_last <= lane_last;
                    rem      <= lane_rest;
                    hold_cnt <= '0;
                end
                DATA, HOLD: begin
                    if (lane_end) begin
                        if (!is_wr) rdata[bus_ind*8 +: 8] <= bus_in;
                        hold_cnt <= '0;
                        if (cur_last) begin
                            state   <= DONE;
                            bus_out <= '0;
                            bus_wr  <= 1'b0;
                            bus_ind <= '0;
                            rdone   <= !is_wr;
                            wdone   <= is_wr;
                        end else begin
                            state    <= DATA;
                            bus_ind  <= lane_idx;
                            bus_out  <= lane_byte;
                            bus_wr   <= is_wr;
                            cur_last <= lane_last;
                            rem      <= lane_rest;
                        end
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= hold_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= RECOV;
                    rdone <= 1'b0;
                    wdone <= 1'b0;
                end
                RECOV:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge.sv
module tb_ext_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [23:0] raddr, waddr;
    logic [3:0]  rreq, wmask;
    logic [31:0] wdata;
    logic [7:0]  bus_in;

    // DUT0: RV=16 PV=18 WAIT=0
    logic [15:0] rdata0;
    logic        rd0, wd0, lh0, ll0, wr0;
    logic [7:0]  bo0;
    logic [0:0]  ind0;
    // DUT1: RV=32 PV=20 WAIT=2
    logic [31:0] rdata1;
    logic        rd1, wd1, lh1, ll1, wr1;
    logic [7:0]  bo1;
    logic [1:0]  ind1;

    always #5 clk = ~clk;

    ext_bus_bridge #(.RV(16), .PV(18), .WAIT(0)) u0 (
        .clk(clk), .reset_in(rst), .ena(ena),
        .raddr(raddr[16:0]), .rreq(rreq[1:0]), .rdata(rdata0), .rdone(rd0),
        .waddr(waddr[16:0]), .wmask(wmask[1:0]), .wdata(wdata[15:0]), .wdone(wd0),
        .bus_out(bo0), .bus_in(bus_in), .latch_hi(lh0), .latch_lo(ll0),
        .bus_wr(wr0), .bus_ind(ind0)
    );

    ext_bus_bridge #(.RV(32), .PV(20), .WAIT(2)) u1 (
        .clk(clk), .reset_in(rst), .ena(ena),
        .raddr(raddr[17:0]), .rreq(rreq), .rdata(rdata1), .rdone(rd1),
        .waddr(waddr[17:0]), .wmask(wmask), .wdata(wdata), .wdone(wd1),
        .bus_out(bo1), .bus_in(bus_in), .latch_hi(lh1), .latch_lo(ll1),
        .bus_wr(wr1), .bus_ind(ind1)
    );

    // ---------------- behavioural model ----------------
    // A transaction is expanded at accept time into the list of bus beats
    // (one per enabled clock) it must produce.
    typedef struct packed {
        logic [7:0]  bo;
        logic        lh, ll, wr;
        logic [1:0]  ind;
        logic        rd, wd, samp, cupd;
        logic [23:0] tag;
    } beat_t;

    int          d, nl, ab, wt, pv;
    beat_t       q[$];
    beat_t       cur;
    bit          busy, cvld;
    int          ctag;
    logic [31:0] mrdata;
    int          checks = 0, failures = 0, cyc = 0;

    logic [7:0]  obs_bo[64];
    logic        obs_lh[64], obs_ll[64], obs_wr[64];
    logic [1:0]  obs_ind[64];

    task automatic set_dut(input int dd);
        d  = dd;
        nl = (dd == 0) ? 2 : 4;
        ab = (dd == 0) ? 1 : 2;
        wt = (dd == 0) ? 0 : 2;
        pv = (dd == 0) ? 18 : 20;
    endtask

    function automatic void mdl_reset();
        q.delete();
        cur    = '0;
        busy   = 0;
        cvld   = 0;
        ctag   = 0;
        mrdata = '0;
    endfunction

    function automatic void build(input bit w, input int addr, input int mask, input logic [31:0] wd);
        beat_t b;
        int ba;
        ba = addr << ab;
        if (!(cvld && ctag == (ba >> 8))) begin
            b = '0; b.bo = 8'((ba >> 16) & ((1 << (pv - 16)) - 1)); b.lh = 1; q.push_back(b);
            b = '0; b.bo = 8'(ba >> 8); b.lh = 1; b.ll = 1; b.cupd = 1; b.tag = 24'(ba >> 8);
            q.push_back(b);
        end
        b = '0; b.bo = 8'(ba); b.ll = 1; q.push_back(b);
        for (int k = 0; k < nl; k++) begin
            if (mask[k]) begin
                for (int c = 0; c <= wt; c++) begin
                    b = '0;
                    b.bo   = w ? wd[k*8 +: 8] : 8'h00;
                    b.wr   = w;
                    b.ind  = 2'(k);
                    b.samp = !w && (c == wt);
                    q.push_back(b);
                end
            end
        end
        b = '0; b.rd = !w; b.wd = w; q.push_back(b);
        b = '0; q.push_back(b);   // recovery cycle
    endfunction

    function automatic void pop();
        cur = q.pop_front();
        if (cur.cupd) begin
            cvld = 1;
            ctag = int'(cur.tag);
        end
    endfunction

    // Effect of one rising edge, from the inputs currently applied.
    function automatic void mdl_step();
        int wm, rq, amask;
        amask = (1 << (pv - ab)) - 1;
        wm = int'(wmask) & ((1 << nl) - 1);
        rq = int'(rreq) & ((1 << nl) - 1);
        if (!ena) return;
        if (busy) begin
            if (cur.samp) mrdata[cur.ind*8 +: 8] = bus_in;
            if (q.size() > 0) pop();
            else begin
                busy = 0;
                cur  = '0;
            end
        end else if (wm != 0 || rq != 0) begin
            if (wm != 0) build(1, int'(waddr) & amask, wm, wdata);
            else         build(0, int'(raddr) & amask, rq, 32'h0);
            pop();
            busy = 1;
        end
    endfunction

    task automatic compare();
        logic [14:0] got, exp;
        logic [31:0] grd;
        if (d == 0) begin
            got = {bo0, lh0, ll0, wr0, 1'b0, ind0, rd0, wd0};
            grd = {16'h0, rdata0};
        end else begin
            got = {bo1, lh1, ll1, wr1, ind1, rd1, wd1};
            grd = rdata1;
        end
        exp = {cur.bo, cur.lh, cur.ll, cur.wr, cur.ind, cur.rd, cur.wd};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL dut%0d ctl cyc=%0d got=%h exp=%h", d, cyc, got, exp);
        end
        checks++;
        if (grd !== mrdata) begin
            failures++;
            $display("FAIL dut%0d rdata cyc=%0d got=%h exp=%h", d, cyc, grd, mrdata);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick(input logic r);
        rst = r;
        if (r) mdl_reset();
        else   mdl_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    // Ticks with the current inputs until DUT d pulses done; records the
    // bus signals seen on each cycle (index 1 = first cycle after accept).
    task automatic run_until_done(input int maxc, input int frz_at, input int frz_len, output int dc);
        dc = -1;
        for (int k = 1; k <= maxc; k++) begin
            ena = !(k >= frz_at && k < frz_at + frz_len);
            tick(1'b0);
            obs_bo[k]  = (d == 0) ? bo0 : bo1;
            obs_lh[k]  = (d == 0) ? lh0 : lh1;
            obs_ll[k]  = (d == 0) ? ll0 : ll1;
            obs_wr[k]  = (d == 0) ? wr0 : wr1;
            obs_ind[k] = (d == 0) ? {1'b0, ind0} : ind1;
            if ((d == 0) ? (rd0 | wd0) : (rd1 | wd1)) begin
                dc = k;
                break;
            end
        end
        ena = 1'b1;
        if (dc < 0) begin
            checks++;
            failures++;
            $display("FAIL dut%0d timeout waiting for done", d);
        end
    endtask

    function automatic logic [23:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 24'h12340 | 24'($urandom_range(0, 15));
        return 24'($urandom);
    endfunction

    initial begin
        int dc;
        rst = 1'b1; ena = 1'b1;
        raddr = '0; waddr = '0; rreq = '0; wmask = '0; wdata = '0; bus_in = '0;
        set_dut(0);
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        compare();
        chk("reset_state0", {bo0, lh0, ll0, wr0, ind0, rd0, wd0, rdata0}, 32'h0);
        chk("reset_state1", {rdata1}, 32'h0);
        tick(1'b0);

        // Miss write, two lanes: 0x12345 word -> byte address 0x2468A.
        waddr = 24'h12345; wdata = 32'h0000BEEF; wmask = 4'h3;
        run_until_done(20, 0, 0, dc);
        chk("wr_done_cyc", dc, 6);
        chk("a_hi", {obs_bo[1], obs_lh[1], obs_ll[1]}, {8'h02, 2'b10});
        chk("a_mid", {obs_bo[2], obs_lh[2], obs_ll[2]}, {8'h46, 2'b11});
        chk("a_lo", {obs_bo[3], obs_lh[3], obs_ll[3]}, {8'h8A, 2'b01});
        chk("lane0", {obs_bo[4], obs_wr[4], obs_ind[4]}, {8'hEF, 1'b1, 2'd0});
        chk("lane1", {obs_bo[5], obs_wr[5], obs_ind[5]}, {8'hBE, 1'b1, 2'd1});
        wmask = 4'h0;
        tick(1'b0); tick(1'b0);

        // Read hitting the cached upper address goes straight to A_LO.
        raddr = 24'h12340; rreq = 4'h3; bus_in = 8'h3C;
        run_until_done(20, 0, 0, dc);
        chk("hit_done_cyc", dc, 4);
        chk("hit_a_lo", {obs_bo[1], obs_lh[1], obs_ll[1]}, {8'h80, 2'b01});
        chk("hit_rdata", {16'h0, rdata0}, 32'h3C3C);
        rreq = 4'h0;
        tick(1'b0); tick(1'b0);

        // Reset asserted in the middle of a data beat.
        waddr = 24'h00400; wdata = 32'h1234; wmask = 4'h1;
        for (int k = 0; k < 4; k++) tick(1'b0);
        chk("pre_rst_data", {wr0, bo0}, {1'b1, 8'h34});
        #2 rst = 1'b1;
        #1 chk("async_rst", {bo0, lh0, ll0, wr0, ind0, rd0, wd0, rdata0}, 32'h0);
        mdl_reset();
        @(negedge clk);
        cyc++;
        compare();
        run_until_done(20, 0, 0, dc);
        chk("post_rst_done_cyc", dc, 5);
        chk("post_rst_a_hi", {obs_lh[1], obs_ll[1]}, 2'b10);
        wmask = 4'h0;
        tick(1'b0); tick(1'b0);

        // Write and read raised together: write first, read after RECOV.
        waddr = 24'h00400; wdata = 32'h7700; wmask = 4'h2;
        raddr = 24'h00401; rreq = 4'h1; bus_in = 8'h11;
        run_until_done(20, 0, 0, dc);
        chk("wr_first", {27'h0, wd0, dc[3:0]}, {27'h0, 1'b1, 4'd3});
        wmask = 4'h0;
        run_until_done(20, 0, 0, dc);
        chk("rd_second", {27'h0, rd0, dc[3:0]}, {27'h0, 1'b1, 4'd5});
        chk("rd_second_a_lo", {obs_lh[3], obs_ll[3]}, 2'b01);
        chk("rd_second_rdata", {16'h0, rdata0}, 32'h0011);
        rreq = 4'h0;
        tick(1'b0); tick(1'b0);

        // Wide port with hold cycles.
        set_dut(1);
        tick(1'b1);
        raddr = 24'h0; rreq = 4'b0100; bus_in = 8'h5A;
        run_until_done(20, 0, 0, dc);
        chk("w2_done_cyc", dc, 7);
        chk("w2_ind_held", {obs_ind[4], obs_ind[5], obs_ind[6]}, {2'd2, 2'd2, 2'd2});
        chk("w2_rdata", rdata1, 32'h005A0000);
        rreq = 4'h0;
        tick(1'b0); tick(1'b0);

        // Clock enable low for 5 cycles mid-transaction.
        raddr = 24'h01000; rreq = 4'b0010; bus_in = 8'h77;
        run_until_done(40, 3, 5, dc);
        chk("ena_done_cyc", dc, 12);
        chk("ena_rdata", rdata1, 32'h005A7700);
        rreq = 4'h0;
        tick(1'b0); tick(1'b0);

        // Randomized traffic on each configuration.
        for (int dd = 0; dd < 2; dd++) begin
            set_dut(dd);
            tick(1'b1);
            for (int n = 0; n < 1500; n++) begin
                wmask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                rreq   = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
                raddr  = pick_addr();
                waddr  = pick_addr();
                wdata  = $urandom;
                bus_in = 8'($urandom);
                ena    = ($urandom_range(0, 9) != 0);
                tick($urandom_range(0, 299) == 0);
            end
            ena = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
